// File: rtl/core7_cpu_6_oci_dct_packer_pkg.sv
// Shared constants and slot-state encoding for the OCI trace-code packer.
package core7_oci_pkg;

  localparam int DCT_CODE_W = 2;
  localparam int DCT_FRAMES = 15;
  localparam int DCT_BUF_W  = 30;
  localparam int DCT_CNT_W  = 4;

  // Frame count at which the accumulator holds a complete word.
  localparam logic [DCT_CNT_W-1:0] DCT_FULL_CNT = DCT_CNT_W'(DCT_FRAMES);

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    HOLD       = 2'd1,
    FLUSH_WAIT = 2'd2
  } slot_state_e;

endpackage

// File: rtl/core7_cpu_6_oci_dct_packer_if.sv
// Trace-code input, flush request and packed-word output of the packer.
interface core7_cpu_6_oci_dct_packer_if #(
  parameter int DROP_CNT_W = 8
) ();
  import core7_oci_pkg::*;

  logic                  dct_valid;
  logic [DCT_CODE_W-1:0] dct_code;
  logic                  flush;
  logic                  out_ready;
  logic [DCT_BUF_W-1:0]  dct_buffer;
  logic [DCT_CNT_W-1:0]  dct_count;
  logic                  buf_valid;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_count;

  // Trace source plus downstream consumer.
  modport master (
    output dct_valid, dct_code, flush, out_ready,
    input  dct_buffer, dct_count, buf_valid, overflow, drop_count
  );

  // The packer.
  modport slave (
    input  dct_valid, dct_code, flush, out_ready,
    output dct_buffer, dct_count, buf_valid, overflow, drop_count
  );

endinterface

// File: rtl/core7_cpu_6_oci_dct_packer_slot.sv
// Registered output slot: holds one packed word until the consumer takes it.
module core7_oci_dct_slot
  import core7_oci_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buf,
  input  logic [DCT_CNT_W-1:0] load_cnt,
  input  logic                 out_ready,
  output logic                 free,
  output logic                 buf_valid,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count
);

  // A word leaving this cycle frees the slot for a back-to-back load.
  assign free = !buf_valid || out_ready;

  // Load a new word, or drop valid on a handshake; data holds after draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (load) begin
      buf_valid  <= 1'b1;
      dct_buffer <= load_buf;
      dct_count  <= load_cnt;
    end else if (buf_valid && out_ready) begin
      buf_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/core7_cpu_6_oci_dct_packer.sv
// Packs 2-bit trace codes into 15-frame words, with flush and drop accounting.
//
// state      | meaning
// EMPTY      | output slot free, no flush pending
// HOLD       | output slot occupied, no flush pending
// FLUSH_WAIT | flush pending, partial word waits for a free slot
module core7_cpu_6_oci_dct_packer
  import core7_oci_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input logic clk,
  input logic reset_n,
  core7_cpu_6_oci_dct_packer_if.slave bus
);

  logic [DCT_BUF_W-1:0]  acc;
  logic [DCT_CNT_W-1:0]  acc_cnt;
  logic                  acc_full;
  logic                  slot_free;
  logic                  transfer;
  logic                  accept;
  logic                  drop;
  logic                  flush_pend;
  logic                  pend_nxt;
  logic                  hold_nxt;
  slot_state_e           state;
  slot_state_e           state_nxt;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  ovf;

  // Transfer, accept and drop decisions for this cycle.
  always_comb begin
    acc_full = (acc_cnt == DCT_FULL_CNT);
    transfer = slot_free && (acc_full || (flush_pend && (acc_cnt != '0)));
    accept   = bus.dct_valid && (!acc_full || transfer);
    drop     = bus.dct_valid && acc_full && !transfer;
  end

  // Accumulator: a transfer empties it, and a same-cycle code lands as frame 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (transfer) begin
      acc     <= accept ? {{(DCT_BUF_W-DCT_CODE_W){1'b0}}, bus.dct_code} : '0;
      acc_cnt <= accept ? DCT_CNT_W'(1) : '0;
    end else if (accept) begin
      acc     <= {acc[DCT_BUF_W-DCT_CODE_W-1:0], bus.dct_code};
      acc_cnt <= acc_cnt + DCT_CNT_W'(1);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign bus.overflow   = ovf;
  assign bus.drop_count = drop_cnt;

  // Slot/flush state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  assign flush_pend = (state == FLUSH_WAIT);

  // Next state. A flush arriving with a transfer only stays pending if it
  // brought a code into the freshly emptied accumulator; a flush with
  // nothing to emit is satisfied at once.
  always_comb begin
    pend_nxt  = 1'b0;
    hold_nxt  = 1'b0;
    state_nxt = state;
    if (transfer) pend_nxt = bus.flush && accept;
    else          pend_nxt = (bus.flush || flush_pend) && ((acc_cnt != '0) || accept);
    hold_nxt = transfer || (bus.buf_valid && !bus.out_ready);
    if (pend_nxt)      state_nxt = FLUSH_WAIT;
    else if (hold_nxt) state_nxt = HOLD;
    else               state_nxt = EMPTY;
  end

  core7_oci_dct_slot u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (transfer),
    .load_buf   (acc),
    .load_cnt   (acc_cnt),
    .out_ready  (bus.out_ready),
    .free       (slot_free),
    .buf_valid  (bus.buf_valid),
    .dct_buffer (bus.dct_buffer),
    .dct_count  (bus.dct_count)
  );

endmodule

// File: tb/tb_core7_cpu_6_oci_dct_packer.sv
// Scoreboard bench for the trace-code packer with a queue-based reference model.
module tb_core7_cpu_6_oci_dct_packer;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  core7_cpu_6_oci_dct_packer_if #(.DROP_CNT_W(8)) bus ();

  core7_cpu_6_oci_dct_packer #(.DROP_CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] w;
    logic [3:0]  c;
  } word_t;

  // Reference model: pending codes as a queue of frames, oldest first.
  int    acc_q[$];
  word_t exp_q[$];
  bit    m_slot;
  bit    m_fp;
  int    m_drops;
  bit    m_ovf;

  logic [29:0] last_word;
  logic [3:0]  last_cnt;
  int          words_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    acc_q.delete();
    exp_q.delete();
    m_slot  = 0;
    m_fp    = 0;
    m_drops = 0;
    m_ovf   = 0;
  endtask

  task automatic model_cycle(input bit v, input int c, input bit f, input bit r);
    bit    free;
    bit    xfer;
    bit    took;
    word_t wd;
    free = !m_slot || r;
    xfer = free && (acc_q.size() == 15 || (m_fp && acc_q.size() != 0));
    if (xfer) begin
      wd.w = '0;
      foreach (acc_q[i]) wd.w = (wd.w << 2) | 30'(acc_q[i]);
      wd.c = 4'(acc_q.size());
      exp_q.push_back(wd);
      acc_q.delete();
      m_slot = 1;
    end else if (m_slot && r) begin
      m_slot = 0;
    end
    took = 0;
    if (v) begin
      if (acc_q.size() < 15) begin
        acc_q.push_back(c);
        took = 1;
      end else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (xfer) m_fp = f && took;
    else      m_fp = (f || m_fp) && (acc_q.size() != 0);
  endtask

  // Apply one cycle of inputs, advance the model, then step past the edge.
  task automatic step(input bit v, input int c, input bit f, input bit r);
    bus.dct_valid = v;
    bus.dct_code  = 2'(c);
    bus.flush     = f;
    bus.out_ready = r;
    model_cycle(v, c, f, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, 0, r);
  endtask

  // Monitor: compares every handshaked word against the scoreboard and
  // checks that a stalled word does not change.
  bit          held = 0;
  logic [29:0] held_w;
  logic [3:0]  held_c;
  always @(negedge clk) begin
    if (!reset_n) begin
      held = 0;
    end else begin
      if (held && bus.buf_valid) begin
        chk("stall_buffer", 32'(bus.dct_buffer), 32'(held_w));
        chk("stall_count", 32'(bus.dct_count), 32'(held_c));
      end
      if (bus.buf_valid && bus.out_ready) begin
        words_seen++;
        last_word = bus.dct_buffer;
        last_cnt  = bus.dct_count;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h/%0d expected none", bus.dct_buffer, bus.dct_count);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("word_buffer", 32'(bus.dct_buffer), 32'(e.w));
          chk("word_count", 32'(bus.dct_count), 32'(e.c));
        end
      end
      held   = bus.buf_valid && !bus.out_ready;
      held_w = bus.dct_buffer;
      held_c = bus.dct_count;
    end
  end

  initial begin
    int w0;
    reset_n       = 1'b0;
    bus.dct_valid = 1'b0;
    bus.dct_code  = 2'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_buf_valid", 32'(bus.buf_valid), 0);
    chk("rst_count", 32'(bus.dct_count), 0);
    chk("rst_buffer", 32'(bus.dct_buffer), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_drop_count", 32'(bus.drop_count), 0);
    reset_n = 1'b1;
    idle(2, 1);

    // Full word of 0,1,2,3,... at full rate.
    w0 = words_seen;
    for (int i = 0; i < 15; i++) step(1, i % 4, 0, 1);
    idle(3, 1);
    chk("full_words", words_seen - w0, 1);
    chk("full_buffer", 32'(last_word), 32'h06C6C6C6);
    chk("full_count", 32'(last_cnt), 15);
    chk("full_overflow", 32'(bus.overflow), 0);

    // Partial word 3,2,1 flushed.
    step(1, 3, 0, 1);
    step(1, 2, 0, 1);
    step(1, 1, 0, 1);
    step(0, 0, 1, 1);
    idle(3, 1);
    chk("flush3_buffer", 32'(last_word), 32'h39);
    chk("flush3_count", 32'(last_cnt), 3);

    // Flush on an empty accumulator, then a single code flushed.
    w0 = words_seen;
    step(0, 0, 1, 1);
    idle(3, 1);
    chk("flush_empty_words", words_seen - w0, 0);
    step(1, 2, 0, 1);
    step(0, 0, 1, 1);
    idle(3, 1);
    chk("flush1_buffer", 32'(last_word), 32'h2);
    chk("flush1_count", 32'(last_cnt), 1);

    // Reset mid-word with a word parked in the slot.
    for (int i = 0; i < 22; i++) step(1, $urandom_range(0, 3), 0, 0);
    chk("pre_rst_valid", 32'(bus.buf_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_buf_valid", 32'(bus.buf_valid), 0);
    chk("mid_rst_count", 32'(bus.dct_count), 0);
    chk("mid_rst_buffer", 32'(bus.dct_buffer), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    w0 = words_seen;
    idle(5, 1);
    chk("post_rst_words", words_seen - w0, 0);

    // Stalled consumer: 32 codes, two dropped, then both words drain in order.
    w0 = words_seen;
    for (int i = 0; i < 32; i++) step(1, $urandom_range(0, 3), 0, 0);
    chk("stall_overflow", 32'(bus.overflow), 1);
    chk("stall_drops", 32'(bus.drop_count), 2);
    idle(5, 1);
    chk("stall_words", words_seen - w0, 2);

    // 16th code coincides with the transfer and starts the next word.
    for (int i = 0; i < 15; i++) step(1, i % 4, 0, 1);
    step(1, 3, 0, 1);
    step(0, 0, 1, 1);
    idle(3, 1);
    chk("x16_buffer", 32'(last_word), 32'h3);
    chk("x16_count", 32'(last_cnt), 1);
    chk("x16_drops", 32'(bus.drop_count), 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 3),
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    step(0, 0, 1, 1);
    idle(20, 1);
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_drops", 32'(bus.drop_count), 32'(m_drops));
    chk("rand_overflow", 32'(bus.overflow), 32'(m_ovf));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
